// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared decode constants, FSM state type and sign helper for the HI/LO
// multiply/divide sequencer.
package hilo_muldiv_ctrl_pkg;

    localparam logic [5:0] R_FORM = 6'h00;
    localparam logic [5:0] MFHI   = 6'h10;
    localparam logic [5:0] MTHI   = 6'h11;
    localparam logic [5:0] MFLO   = 6'h12;
    localparam logic [5:0] MTLO   = 6'h13;
    localparam logic [5:0] MULT   = 6'h18;
    localparam logic [5:0] MULTU  = 6'h19;
    localparam logic [5:0] DIV    = 6'h1A;
    localparam logic [5:0] DIVU   = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Absolute value for signed ops; 0x80000000 maps to itself, which is
    // the correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic signed_op);
        return (signed_op && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_muldiv_step.sv
// One iteration of shift-add multiply (mode=0) or restoring divide (mode=1)
// over a {hi,lo} accumulator.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic                mode,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   acc_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_shift;
    logic [XLEN:0] diff;

    always_comb begin
        sum       = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        rem_shift = acc[2*XLEN-1:XLEN-1];
        diff      = rem_shift - {1'b0, operand};
        if (mode) begin
            // Borrow out of the 33-bit subtract means the trial remainder was too small.
            if (!diff[XLEN])
                acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_next = {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            acc_next = {sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: accepts MULT/MULTU/DIV/DIVU and MTxx/MFxx from EX, iterates
// the arithmetic over several cycles and stalls HI/LO users while busy.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BITS_PER_CYC = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            en,
    input  logic [31:0]     Ins,
    input  logic [XLEN-1:0] Rdata1,
    input  logic [XLEN-1:0] Rdata2,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO,
    output logic            stall,
    output logic            busy
);

    localparam int N  = XLEN / BITS_PER_CYC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [2*XLEN-1:0] acc_reg, acc_next;
    logic [XLEN-1:0]   opnd_reg, opnd_next;
    logic              is_div_reg, is_div_next;
    logic              neg_res_reg, neg_res_next;
    logic              neg_rem_reg, neg_rem_next;
    logic [XLEN-1:0]   hi_reg, hi_next;
    logic [XLEN-1:0]   lo_reg, lo_next;
    logic              busy_reg;

    logic [5:0]        funct;
    logic              r_form, md_op, hl_op;
    logic              signed_op, div_op;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    logic              unused_ins;

    assign funct      = Ins[5:0];
    assign r_form     = en && (Ins[31:26] == R_FORM);
    assign md_op      = r_form && (funct == MULT || funct == MULTU || funct == DIV || funct == DIVU);
    assign hl_op      = r_form && (funct == MFHI || funct == MTHI || funct == MFLO || funct == MTLO);
    assign unused_ins = ^Ins[25:6];

    logic [BITS_PER_CYC:0][2*XLEN-1:0] chain;
    assign chain[0] = acc_reg;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYC; gi++) begin : g_step
            muldiv_step #(.XLEN(XLEN)) u_step (
                .mode     (is_div_reg),
                .acc      (chain[gi]),
                .operand  (opnd_reg),
                .acc_next (chain[gi+1])
            );
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        acc_next     = acc_reg;
        opnd_next    = opnd_reg;
        is_div_next  = is_div_reg;
        neg_res_next = neg_res_reg;
        neg_rem_next = neg_rem_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        signed_op    = (funct == MULT) || (funct == DIV);
        div_op       = (funct == DIV) || (funct == DIVU);
        a_mag        = magnitude(Rdata1, signed_op);
        b_mag        = magnitude(Rdata2, signed_op);
        prod         = neg_res_reg ? (2*XLEN)'(0) - acc_reg : acc_reg;
        quo          = neg_res_reg ? XLEN'(0) - acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
        rem          = neg_rem_reg ? XLEN'(0) - acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];

        unique case (state_reg)
            ST_IDLE: begin
                if (md_op) begin
                    is_div_next = div_op;
                    cnt_next    = '0;
                    if (div_op && Rdata2 == '0) begin
                        // Forced divide-by-zero result rides through FIX unsigned.
                        acc_next     = {Rdata1, {XLEN{1'b1}}};
                        neg_res_next = 1'b0;
                        neg_rem_next = 1'b0;
                        state_next   = ST_FIX;
                    end else begin
                        opnd_next    = div_op ? b_mag : a_mag;
                        acc_next     = {{XLEN{1'b0}}, (div_op ? a_mag : b_mag)};
                        neg_res_next = signed_op && (Rdata1[XLEN-1] ^ Rdata2[XLEN-1]);
                        neg_rem_next = signed_op && div_op && Rdata1[XLEN-1];
                        state_next   = ST_CALC;
                    end
                end else if (r_form && funct == MTHI) begin
                    hi_next = Rdata1;
                end else if (r_form && funct == MTLO) begin
                    lo_next = Rdata1;
                end
            end
            ST_CALC: begin
                acc_next = chain[BITS_PER_CYC];
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == CW'(N - 1))
                    state_next = ST_FIX;
            end
            ST_FIX: begin
                if (is_div_reg) begin
                    hi_next = rem;
                    lo_next = quo;
                end else begin
                    hi_next = prod[2*XLEN-1:XLEN];
                    lo_next = prod[XLEN-1:0];
                end
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            opnd_reg    <= '0;
            is_div_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            acc_reg     <= acc_next;
            opnd_reg    <= opnd_next;
            is_div_reg  <= is_div_next;
            neg_res_reg <= neg_res_next;
            neg_rem_reg <= neg_rem_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            busy_reg    <= (state_next != ST_IDLE);
        end
    end

    assign HI    = hi_reg;
    assign LO    = lo_reg;
    assign busy  = busy_reg;
    assign stall = (md_op || hl_op) && (state_reg != ST_IDLE);

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed plus randomized checks of the HI/LO sequencer against a plain
// arithmetic model of the instruction results.
module tb_hilo_muldiv_ctrl;

    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam int         OP_CYCLES = 33;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        en = 1'b0;
    logic [31:0] Ins = '0;
    logic [31:0] Rdata1 = '0;
    logic [31:0] Rdata2 = '0;
    logic [31:0] HI, LO;
    logic        stall, busy;

    int checks = 0;
    int failures = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    hilo_muldiv_ctrl dut (
        .CLK(CLK), .RST(RST), .en(en), .Ins(Ins),
        .Rdata1(Rdata1), .Rdata2(Rdata2),
        .HI(HI), .LO(LO), .stall(stall), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            F_MULT:  begin q = sa * sb; p = q; end
            F_MULTU: p = {32'd0, a} * {32'd0, b};
            F_DIV:   if (b == 0) p = {a, 32'hFFFFFFFF};
                     else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
            default: if (b == 0) p = {a, 32'hFFFFFFFF};
                     else p = {a % b, a / b};
        endcase
        return p;
    endfunction

    task automatic present(input logic [5:0] op, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        en = 1'b1; Ins = {op, 20'd0, f}; Rdata1 = a; Rdata2 = b;
    endtask

    task automatic idle_inputs();
        en = 1'b0; Ins = '0;
    endtask

    // Issue one MD op from idle, scramble operands during CALC, measure busy.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        int cyc, exp_cyc;
        @(negedge CLK);
        present(6'd0, f, a, b);
        @(negedge CLK);
        idle_inputs();
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            Rdata1 = $urandom; Rdata2 = $urandom;
            @(negedge CLK);
        end
        r = model(f, a, b);
        hi_m = r[63:32]; lo_m = r[31:0];
        exp_cyc = ((f == F_DIV || f == F_DIVU) && b == 0) ? 1 : OP_CYCLES;
        check({tag, "_cycles"}, cyc, exp_cyc);
        check({tag, "_hi"}, HI, hi_m);
        check({tag, "_lo"}, LO, lo_m);
        $display("op %s f=%h a=%h b=%h -> HI=%h LO=%h busy_cycles=%0d", tag, f, a, b, HI, LO, cyc);
    endtask

    task automatic run_mt(input logic [5:0] f, input logic [31:0] a);
        @(negedge CLK);
        present(6'd0, f, a, 32'd0);
        @(negedge CLK);
        idle_inputs();
        if (f == F_MTHI) hi_m = a; else lo_m = a;
        check("mt_hi", HI, hi_m);
        check("mt_lo", LO, lo_m);
        $display("op mt f=%h a=%h -> HI=%h LO=%h", f, a, HI, LO);
    endtask

    initial begin
        int cyc;
        logic [5:0] fr;
        logic [31:0] ra, rb;

        repeat (3) @(negedge CLK);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        RST = 1'b1;

        run_op("mult_7_m3", F_MULT, 32'd7, 32'hFFFFFFFD);
        check("mult_7_m3_lit_hi", HI, 32'hFFFFFFFF);
        check("mult_7_m3_lit_lo", LO, 32'hFFFFFFEB);
        run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("multu_max_lit_hi", HI, 32'hFFFFFFFE);
        run_op("div_m7_2", F_DIV, 32'hFFFFFFF9, 32'd2);
        check("div_m7_2_lit_lo", LO, 32'hFFFFFFFD);
        run_op("divu_100_7", F_DIVU, 32'd100, 32'd7);
        check("divu_100_7_lit", {HI[15:0], LO[15:0]}, {16'd2, 16'd14});
        run_op("divu_by0", F_DIVU, 32'h00001234, 32'd0);
        run_op("div_by0", F_DIV, 32'h80000005, 32'd0);
        run_op("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf_lit_lo", LO, 32'h80000000);

        // Non-R-form opcode with an MD funct must not start anything.
        @(negedge CLK);
        present(6'h08, F_MULT, 32'd9, 32'd9);
        @(negedge CLK);
        check("nonr_busy", {31'd0, busy}, 32'd0);
        present(6'd0, F_MULT, 32'd9, 32'd9);
        en = 1'b0;
        @(negedge CLK);
        check("en0_busy", {31'd0, busy}, 32'd0);
        idle_inputs();

        // MULT 3*5 then ADD (no stall) then MFLO held until idle.
        @(negedge CLK);
        present(6'd0, F_MULT, 32'd3, 32'd5);
        @(negedge CLK);
        present(6'd0, F_ADD, 32'd1, 32'd1);
        #1;
        check("add_stall", {31'd0, stall}, 32'd0);
        check("add_busy", {31'd0, busy}, 32'd1);
        @(negedge CLK);
        present(6'd0, F_MFLO, 32'd0, 32'd0);
        #1;
        cyc = 0;
        while (stall && cyc < 200) begin
            cyc++;
            @(negedge CLK);
            #1;
        end
        check("mflo_stall_cycles", cyc, OP_CYCLES - 1);
        hi_m = 32'd0; lo_m = 32'd15;
        check("mflo_lo", LO, lo_m);
        check("mflo_busy", {31'd0, busy}, 32'd0);
        @(negedge CLK);
        present(6'd0, F_MULTU, 32'd4, 32'd4);
        en = 1'b0;
        #1;
        check("en0_nostall", {31'd0, stall}, 32'd0);
        idle_inputs();
        $display("op stall_mflo stall_cycles=%0d LO=%h", cyc, LO);

        // Reset mid-operation aborts without a HI/LO write.
        run_mt(F_MTHI, 32'hA5A5A5A5);
        @(negedge CLK);
        present(6'd0, F_DIV, 32'd1000, 32'd3);
        @(negedge CLK);
        idle_inputs();
        repeat (10) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        hi_m = 32'd0; lo_m = 32'd0;
        check("mid_rst_hi", HI, 32'd0);
        check("mid_rst_lo", LO, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        $display("op mid_reset -> HI=%h LO=%h busy=%b", HI, LO, busy);
        run_op("mult_2_2", F_MULT, 32'd2, 32'd2);
        run_mt(F_MTLO, 32'h13572468);

        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 5))
                0: fr = F_MULT;
                1: fr = F_MULTU;
                2, 3: fr = F_DIV;
                default: fr = F_DIVU;
            endcase
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
            if ($urandom_range(0, 3) == 0) rb = -rb;
            run_op("rand", fr, ra, rb);
            if ($urandom_range(0, 3) == 0) run_mt($urandom_range(0, 1) ? F_MTHI : F_MTLO, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
